hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_pkg.sv | 16 +
 rtl/mdu_stall_fsm.sv | 65 ++++++
 rtl/hazard_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU pipeline: forwarding mux selects and
// the multi-cycle MDU handshake state.
package cpu_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_stall_fsm.sv
// Tracks an in-flight multiply/divide in E, stalling until it reports done
// or until a watchdog expires, in which case the sticky error flag is raised.
module mdu_stall_fsm
    import cpu_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic mdu_startE,
    input  logic mdu_doneE,
    output logic mdu_stall,
    output logic mdu_busy,
    output logic mdu_err
);

    localparam int CNT_W = $clog2(MDU_TIMEOUT + 1);

    mdu_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             timeout;

    // Last permitted BUSY cycle with no done: release the pipeline now.
    assign timeout   = (state == MDU_BUSY) & ~mdu_doneE
                     & (cnt == CNT_W'(MDU_TIMEOUT - 1));
    assign mdu_busy  = (state == MDU_BUSY);
    assign mdu_stall = ((state == MDU_IDLE) & mdu_startE & ~mdu_doneE)
                     | ((state == MDU_BUSY) & ~mdu_doneE & ~timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MDU_IDLE;
            cnt     <= '0;
            mdu_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (timeout) begin
                mdu_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            MDU_IDLE: begin
                if (mdu_startE & ~mdu_doneE) begin
                    state_nx = MDU_BUSY;
                    cnt_nx   = '0;
                end
            end
            MDU_BUSY: begin
                if (mdu_doneE | timeout) begin
                    state_nx = MDU_IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = MDU_IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding for D and E, load-use and
// branch-operand stalls, and MDU hold/bubble control.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REGW        = 5,
    parameter int MDU_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] rsD,
    input  logic [REGW-1:0] rtD,
    input  logic [REGW-1:0] rsE,
    input  logic [REGW-1:0] rtE,
    input  logic [REGW-1:0] writeregE,
    input  logic [REGW-1:0] writeregM,
    input  logic [REGW-1:0] writeregW,
    input  logic            regwriteE,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            memtoregE,
    input  logic            memtoregM,
    input  logic            branchD,
    input  logic            jumpregD,
    input  logic            redirectD,
    input  logic            mdu_startE,
    input  logic            mdu_doneE,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            forwardAD,
    output logic            forwardBD,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            flushD,
    output logic            flushE,
    output logic            flushM,
    output logic            mdu_busy,
    output logic            mdu_err
);

    logic lwstall, brstall, mdu_stall, any_stall;

    // Register 0 is hard-wired, so it never takes a forwarded value.
    function automatic fwd_sel_t fwd_e(input logic [REGW-1:0] src);
        if (src != '0 && regwriteM && src == writeregM) return FWD_MEM;
        if (src != '0 && regwriteW && src == writeregW) return FWD_WB;
        return FWD_NONE;
    endfunction

    function automatic logic hits_d(input logic [REGW-1:0] dst);
        return (dst != '0) && ((dst == rsD) || (dst == rtD));
    endfunction

    assign forwardAE = fwd_e(rsE);
    assign forwardBE = fwd_e(rtE);
    assign forwardAD = (rsD != '0) & regwriteM & (rsD == writeregM);
    assign forwardBD = (rtD != '0) & regwriteM & (rtD == writeregM);

    assign lwstall = memtoregE & (rtE != '0) & ((rtE == rsD) | (rtE == rtD));
    assign brstall = (branchD | jumpregD)
                   & ((regwriteE & hits_d(writeregE)) | (memtoregM & hits_d(writeregM)));

    mdu_stall_fsm #(
        .MDU_TIMEOUT(MDU_TIMEOUT)
    ) u_mdu (
        .clk        (clk),
        .rst        (rst),
        .mdu_startE (mdu_startE),
        .mdu_doneE  (mdu_doneE),
        .mdu_stall  (mdu_stall),
        .mdu_busy   (mdu_busy),
        .mdu_err    (mdu_err)
    );

    // A held E stage must not be cleared, so the MDU hold wins over flushE.
    assign any_stall = lwstall | brstall | mdu_stall;
    assign stallF    = any_stall;
    assign stallD    = any_stall;
    assign stallE    = mdu_stall;
    assign flushM    = mdu_stall;
    assign flushE    = (lwstall | brstall) & ~mdu_stall;
    assign flushD    = redirectD & ~any_stall;

endmodule
